// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_pkg;
  localparam int AW               = 5;
  localparam int DW               = 32;
  localparam int DEPTH_DEF        = 4;
  localparam int STARVE_LIMIT_DEF = 8;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding long-latency results until a write slot frees up.
module wb_result_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  wb_entry_t       push_entry,
  input  logic            pop,
  output wb_entry_t       head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty
);
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  wb_entry_t     mem [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap without extra logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port: pipeline writeback first, queued
// long-latency results drain into idle slots, starvation raises stall_req.
module wb_port_arbiter
  import rf_pkg::*;
#(
  parameter  int DEPTH        = DEPTH_DEF,
  parameter  int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          stall_req,
  output logic          lu_pending,
  output logic [CW-1:0] fifo_count
);
  logic      wb_write;
  logic      push;
  logic      pop;
  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t lu_entry;
  wb_entry_t head;
  logic [7:0] starve_cnt;

  // Writes to x0 are non-writes and leave the slot free for the FIFO.
  assign wb_write   = wb_valid && (wb_rd != '0);
  assign lu_ready   = reset_n && !fifo_full;
  assign push       = lu_valid && lu_ready;
  assign pop        = !wb_write && !fifo_empty;
  assign lu_pending = !fifo_empty;
  assign stall_req  = (starve_cnt == 8'(STARVE_LIMIT));
  assign lu_entry   = '{rd: lu_rd, data: lu_data};

  wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (lu_entry),
    .pop        (pop),
    .head       (head),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_write || (pop && (head.rd != '0));
      if (wb_write) begin
        rf_waddr <= wb_rd;
        rf_wdata <= wb_data;
      end else if (pop) begin
        rf_waddr <= head.rd;
        rf_wdata <= head.data;
      end
    end
  end

  // Counts cycles a waiting head is blocked; saturates so stall_req stays up.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (fifo_empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_cnt != 8'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 8'd1;
    end
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single integer/FP register-file write port between two sources:
  - the in-order pipeline writeback, i.e. the MEM/WB stage output;
  - results from a long-latency unit (FP div/sqrt, multi-cycle ops) that finish out of step with the pipeline.
- Pipeline writeback always has priority and is never back-pressured.
- Long-latency results are queued in a small FIFO and drain into idle write-port slots.
- A starvation counter requests a pipeline bubble when a queued result has waited too long.

Parameters:
- DEPTH, 4, long-latency result FIFO entries; must be a power of 2, at least 2.
- STARVE_LIMIT, 8, cycles a FIFO head may be blocked before stall_req asserts; range 1 to 255.
- DW, 32, data width.
- AW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_rd  in  AW  pipeline destination register.
- wb_data  in  DW  pipeline writeback data.
- lu_valid  in  1  long-latency result offered.
- lu_ready  out  1  FIFO can accept; a push happens when lu_valid and lu_ready are both high.
- lu_rd  in  AW  long-latency destination register.
- lu_data  in  DW  long-latency result data.
- rf_we  out  1  register-file write enable (registered).
- rf_waddr  out  AW  register-file write address (registered).
- rf_wdata  out  DW  register-file write data (registered).
- stall_req  out  1  asks the pipeline to insert a writeback bubble.
- lu_pending  out  1  FIFO non-empty.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rf_we, rf_waddr, rf_wdata, stall_req and lu_pending are 0; fifo_count is 0.
  - FIFO pointers and starve counter are cleared; all queued entries are lost.
  - lu_ready is forced to 0 while reset_n is low.
- Slot selection is combinational within a cycle and is applied to the rf_* registers at the next rising edge:
  - A pipeline write (wb_valid high, wb_rd not 0) owns the slot.
  - Otherwise, if the FIFO is non-empty, the head is popped and written.
  - Otherwise rf_we is 0 next cycle.
- rd = 0 handling:
  - wb_valid with wb_rd = 0 is a non-write; the slot is free for the FIFO.
  - A FIFO head with rd = 0 is popped in a free slot but produces rf_we = 0.
- Latency:
  - Pipeline write in cycle N appears on the rf_* outputs in cycle N+1.
  - A long-latency push in cycle N becomes the head in N+1. With no contention it is written in N+2; there is no FIFO bypass.
- lu_ready is high exactly when fifo_count < DEPTH.
  - It depends only on registered state, so a same-cycle pop while full does not raise it.
  - A push with a simultaneous pop leaves the count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Entries drain in FIFO order. Register-ordering hazards (WAW, RAW) belong to the issue/scoreboard logic; this block does not check rd matches.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the head is not popped, saturating at STARVE_LIMIT.
  - Cleared on any pop and while the FIFO is empty.
- stall_req is high exactly when the starve counter equals STARVE_LIMIT, and falls the cycle after the head pops.
  - The pipeline answers stall_req with wb_valid = 0.
  - If wb_valid is still high, the pipeline still wins and no data is lost.
- Reset mid-operation: the asynchronous clear takes effect immediately; the first post-reset edge behaves as after power-up.

Decomposition:
- Shared package (rf_pkg): AW, DW, the default DEPTH and STARVE_LIMIT, and a packed wb_entry_t struct {rd, data}.
- Sub-module wb_result_fifo:
  - synchronous FIFO of wb_entry_t with push/pop, count, full and empty;
  - asynchronous active-low reset.
- Arbitration, starve counter and output registers stay in the top module.

Test Plan:
- Pipeline only: wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF in cycle 0 → cycle 1 shows rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; lu_pending=0.
- Idle port: wb_valid=0, lu_valid=1, lu_rd=10, lu_data=0x3F800000 in cycle 0 → fifo_count=1 in cycle 1; cycle 2 shows rf_we=1, rf_waddr=10, rf_wdata=0x3F800000; fifo_count=0.
- Starvation: one push in cycle 0, wb_valid=1 with wb_rd=3 every cycle → stall_req first high in cycle 9. Drop wb_valid in cycle 10 → head written in cycle 11, stall_req=0 in cycle 11.
- Full: 4 pushes while wb_valid stays high → fifo_count=4, lu_ready=0, and a held 5th lu_valid is not accepted. One pop → lu_ready=1 the next cycle, and the 5th entry is pushed.
- rd = 0:
  - wb_valid=1, wb_rd=0 with one entry queued (rd=7) → rd=7 is written next cycle.
  - A queued entry with rd=0 pops and gives rf_we=0.
- Reset: assert reset_n=0 mid-cycle with 3 entries queued and stall_req=1 → all outputs 0 immediately, lu_ready=0. After release, lu_ready=1 and fifo_count=0.
